// File: rtl/game_pkg.sv
// game_pkg: shared state, winner and player-index definitions for the game-round controller.
package game_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1 = 2'd1;
    localparam logic [1:0] WIN_P2 = 2'd2;
    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;
endpackage

// File: rtl/score_arbiter_ctrl_if.sv
// score_arbiter_ctrl_if: player request inputs and score/indicator outputs of the round controller.
interface score_arbiter_ctrl_if #(parameter int SCORE_W = 4);
    logic start;
    logic p1_point;
    logic p2_point;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic p1_grant;
    logic p2_grant;
    logic playing;
    logic game_over;
    logic [1:0] winner;
    modport master (
        output start, p1_point, p2_point,
        input score_p1, score_p2, p1_grant, p2_grant, playing, game_over, winner
    );
    modport slave (
        input start, p1_point, p2_point,
        output score_p1, score_p2, p1_grant, p2_grant, playing, game_over, winner
    );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; a tie goes to the player not granted last.
module rr_arb2
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       last_grant
);
    always_comb grant = &req ? (last_grant == P2 ? 2'b01 : 2'b10) : req;
    always_ff @(posedge clk) begin
        if (rst) last_grant <= P2;
        else if (advance && |req) last_grant <= grant[1] ? P2 : P1;
    end
endmodule

// File: rtl/score_arbiter_ctrl.sv
// score_arbiter_ctrl: two-player round FSM with round-robin arbitrated score updates and win detection.
module score_arbiter_ctrl
    import game_pkg::*;
#(
    parameter int SCORE_W = 4,
    parameter int WIN_SCORE = 9
) (
    input logic clk,
    input logic rst,
    score_arbiter_ctrl_if.slave bus
);
    localparam logic [SCORE_W-1:0] WIN_M1 = SCORE_W'(WIN_SCORE - 1);
    state_t state;
    logic pend1, pend2, last_grant;
    logic [1:0] req, grant, grant_q, winner_q;
    logic [SCORE_W-1:0] s1, s2;
    assign req = state == PLAY ? {pend2 | bus.p2_point, pend1 | bus.p1_point} : 2'b00;
    rr_arb2 u_arb (
        .clk(clk),
        .rst(rst),
        .req(req),
        .advance(state == PLAY),
        .grant(grant),
        .last_grant(last_grant)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            s1 <= '0;
            s2 <= '0;
            grant_q <= 2'b00;
            winner_q <= WIN_NONE;
            pend1 <= 1'b0;
            pend2 <= 1'b0;
        end else begin
            grant_q <= grant;
            case (state)
                PLAY: if (|req) begin
                    // under contention the previous last_grant holder is the loser and keeps its request
                    pend1 <= &req && last_grant == P1;
                    pend2 <= &req && last_grant == P2;
                    if (grant[0]) begin
                        s1 <= s1 + 1'b1;
                        if (s1 == WIN_M1) begin
                            state <= OVER;
                            winner_q <= WIN_P1;
                            pend1 <= 1'b0;
                            pend2 <= 1'b0;
                        end
                    end else begin
                        s2 <= s2 + 1'b1;
                        if (s2 == WIN_M1) begin
                            state <= OVER;
                            winner_q <= WIN_P2;
                            pend1 <= 1'b0;
                            pend2 <= 1'b0;
                        end
                    end
                end
                IDLE, OVER: begin
                    pend1 <= 1'b0;
                    pend2 <= 1'b0;
                    if (bus.start) begin
                        state <= PLAY;
                        s1 <= '0;
                        s2 <= '0;
                        winner_q <= WIN_NONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.score_p1 = s1;
    assign bus.score_p2 = s2;
    assign bus.p1_grant = grant_q[0];
    assign bus.p2_grant = grant_q[1];
    assign bus.winner = winner_q;
    assign bus.playing = state == PLAY;
    assign bus.game_over = state == OVER;
endmodule

// File: tb/tb_score_arbiter_ctrl.sv
// tb_score_arbiter_ctrl: scoreboard bench comparing the controller against a cycle-level game model.
module tb_score_arbiter_ctrl;
    localparam int WIN = 9;
    typedef struct packed {
        logic [3:0] s1;
        logic [3:0] s2;
        logic g1;
        logic g2;
        logic pl;
        logic ov;
        logic [1:0] w;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    exp_t exp_q[$];
    exp_t e, act;
    int mode = 0;
    int sc[1:2] = '{0, 0};
    bit pend[1:2] = '{0, 0};
    int last = 2;
    int win = 0;
    score_arbiter_ctrl_if #(.SCORE_W(4)) bus ();
    score_arbiter_ctrl #(.SCORE_W(4), .WIN_SCORE(WIN)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    // model: mode 0 idle, 1 play, 2 over; players numbered 1 and 2
    task automatic step(input bit r, input bit s, input bit a, input bit b);
        int g;
        bit rq[1:2];
        @(negedge clk);
        rst = r;
        bus.start = s;
        bus.p1_point = a;
        bus.p2_point = b;
        g = 0;
        if (r) begin
            mode = 0; sc[1] = 0; sc[2] = 0; pend[1] = 0; pend[2] = 0; last = 2; win = 0;
        end else if (mode == 1) begin
            rq[1] = pend[1] || a;
            rq[2] = pend[2] || b;
            if (rq[1] && rq[2]) g = 3 - last;
            else if (rq[1]) g = 1;
            else if (rq[2]) g = 2;
            if (g != 0) begin
                sc[g]++;
                last = g;
                pend[g] = 0;
                pend[3 - g] = rq[3 - g];
                if (sc[g] == WIN) begin
                    mode = 2; win = g; pend[1] = 0; pend[2] = 0;
                end
            end
        end else begin
            pend[1] = 0; pend[2] = 0;
            if (s) begin
                mode = 1; sc[1] = 0; sc[2] = 0; win = 0;
            end
        end
        exp_q.push_back('{s1: 4'(sc[1]), s2: 4'(sc[2]), g1: g == 1, g2: g == 2,
                          pl: mode == 1, ov: mode == 2, w: 2'(win)});
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = '{s1: bus.score_p1, s2: bus.score_p2, g1: bus.p1_grant, g2: bus.p2_grant,
                    pl: bus.playing, ov: bus.game_over, w: bus.winner};
            total++;
            if (act !== e)
                begin bad++; $display("FAIL outputs t=%0t got s1=%0d s2=%0d g=%b%b pl=%b ov=%b w=%0d want s1=%0d s2=%0d g=%b%b pl=%b ov=%b w=%0d",
                    $time, act.s1, act.s2, act.g1, act.g2, act.pl, act.ov, act.w, e.s1, e.s2, e.g1, e.g2, e.pl, e.ov, e.w); end
            total++;
            if ((bus.p1_grant && bus.p2_grant) || (bus.playing && bus.game_over))
                begin bad++; $display("FAIL exclusive t=%0t got g=%b%b pl=%b ov=%b want no overlap", $time, bus.p1_grant, bus.p2_grant, bus.playing, bus.game_over); end
        end
    end
    initial begin
        bus.start = 1'b0;
        bus.p1_point = 1'b0;
        bus.p2_point = 1'b0;
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        step(0, 0, 1, 1); step(0, 0, 0, 1); idle(2);
        step(0, 1, 0, 0); step(0, 0, 1, 0); idle(2);
        step(0, 0, 1, 1); idle(2);
        step(0, 0, 1, 1); idle(2);
        step(0, 0, 1, 1); step(0, 0, 1, 1); step(0, 1, 0, 1); idle(3);
        step(0, 1, 0, 0); step(0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
        step(0, 0, 1, 1); step(0, 0, 1, 1); step(0, 0, 0, 1); idle(2);
        step(0, 1, 0, 0); idle(1);
        step(1, 0, 0, 0); step(0, 0, 1, 1); step(0, 0, 1, 0); idle(1);
        step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
        for (int i = 0; i < 3; i++) begin step(0, 0, 0, 1); step(0, 0, 0, 0); end
        step(0, 0, 1, 1); step(1, 1, 0, 1); idle(1);
        step(0, 1, 0, 0); step(0, 0, 1, 1); idle(2);
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        idle(2);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0)
            begin bad++; $display("FAIL drain got %0d pending want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
